// File: rtl/systolic_drain_pkg.sv
// Shared constants and types for the systolic-array drain/requant stage.
// Contents: default accumulator/output widths, exact requant datapath
// widths, INT8 clamp limits and the drain FSM state type.
package systolic_drain_pkg;

    localparam int ACC_W_DEF  = 32;
    localparam int OUT_W_DEF  = 8;

    // 32b acc + 32b bias needs 33b; 33b signed * 17b (zero-extended
    // 16b scale) needs 50b. Rounding constant (<= 2^30) fits without carry out.
    localparam int SUM_W  = 33;
    localparam int PROD_W = 50;

    localparam logic signed [PROD_W-1:0] Q_MAX = PROD_W'(127);
    localparam logic signed [PROD_W-1:0] Q_MIN = PROD_W'(-128);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/systolic_drain_requant_lane.sv
// requant_lane: combinational requantization of one accumulator element.
// Ports:
//   i_acc, i_bias  signed accumulator and bias (ACC_W)
//   i_scale        unsigned 16b multiplier
//   i_shift        arithmetic right shift, 0..31, round half up
//   i_relu_en      clamp negative results to zero before saturation
//   o_q            saturated signed OUT_W result
//   o_clipped      result was outside the INT8 range (after ReLU)
module requant_lane
    import systolic_drain_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [ACC_W-1:0] i_acc,
    input  logic [ACC_W-1:0] i_bias,
    input  logic [15:0]      i_scale,
    input  logic [4:0]       i_shift,
    input  logic             i_relu_en,
    output logic [OUT_W-1:0] o_q,
    output logic             o_clipped
);

    logic signed [SUM_W-1:0]  w_sum;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_rnd;
    logic signed [PROD_W-1:0] w_q;
    logic signed [PROD_W-1:0] w_qr;
    logic                     w_hi;
    logic                     w_lo;

    assign w_sum  = SUM_W'($signed(i_acc)) + SUM_W'($signed(i_bias));
    assign w_prod = PROD_W'(w_sum) * PROD_W'($signed({1'b0, i_scale}));
    assign w_rnd  = (i_shift == 5'd0) ? '0 : (PROD_W'(1) << (i_shift - 5'd1));
    assign w_q    = (w_prod + w_rnd) >>> i_shift;
    assign w_qr   = (i_relu_en && w_q[PROD_W-1]) ? '0 : w_q;

    assign w_hi      = (w_qr > Q_MAX);
    assign w_lo      = (w_qr < Q_MIN);
    assign o_clipped = w_hi | w_lo;
    assign o_q       = w_hi ? Q_MAX[OUT_W-1:0] :
                       w_lo ? Q_MIN[OUT_W-1:0] : w_qr[OUT_W-1:0];

endmodule

// File: rtl/systolic_drain_requant.sv
// systolic_drain_requant: snapshots the systolic array accumulators on
// i_start and streams requantized INT8 rows over a valid/ready interface.
// Ports:
//   i_clk, i_rst (sync, active high), i_start
//   i_acc_in_flat  element (r,c) at ((N_ROWS*N_COLS-1-(r*N_COLS+c))*ACC_W)
//   i_bias_flat    lane c at [c*ACC_W +: ACC_W]
//   i_scale, i_shift, i_relu_en  requant config, latched at start
//   o_out_valid/i_out_ready, o_out_data (lane c at [c*OUT_W +: OUT_W]),
//   o_out_row, o_out_last, o_busy, o_done
// Optional: DRAIN_SAT_COUNT_EN adds o_sat_count, the count of clipped
// lanes over accepted beats of the current drain (saturating at FFFF).
//
// state  | meaning
// IDLE   | waiting for i_start; outputs idle
// STREAM | rows being requantized and handed out, one per handshake
module systolic_drain_requant
    import systolic_drain_pkg::*;
#(
    parameter int N_ROWS = 14,
    parameter int N_COLS = 14,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_start,
    input  logic [N_ROWS*N_COLS*ACC_W-1:0]  i_acc_in_flat,
    input  logic [N_COLS*ACC_W-1:0]         i_bias_flat,
    input  logic [15:0]                     i_scale,
    input  logic [4:0]                      i_shift,
    input  logic                            i_relu_en,
    output logic                            o_out_valid,
    input  logic                            i_out_ready,
    output logic [N_COLS*OUT_W-1:0]         o_out_data,
    output logic [ROW_W-1:0]                o_out_row,
    output logic                            o_out_last,
    output logic                            o_busy,
    output logic                            o_done
`ifdef DRAIN_SAT_COUNT_EN
    ,output logic [15:0]                    o_sat_count
`endif
);

    localparam int NEL   = N_ROWS * N_COLS;
    localparam int CNT_W = $clog2(N_COLS + 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);

    state_t r_state, w_state_next;

    logic [ACC_W-1:0]        r_snap [N_ROWS][N_COLS];
    logic [N_COLS*ACC_W-1:0] r_bias;
    logic [15:0]             r_scale;
    logic [4:0]              r_shift;
    logic                    r_relu;
    logic [ROW_W-1:0]        r_row_ptr;
    logic                    r_have_next;

    logic                    w_xfer;
    logic                    w_capture;
    logic                    w_load;
    logic                    w_finish;
    logic [N_COLS*OUT_W-1:0] w_row_q;
    logic [N_COLS-1:0]       w_clip;

    assign w_xfer    = o_out_valid && i_out_ready;
    assign w_capture = (r_state == IDLE) && i_start;
    assign w_finish  = w_xfer && o_out_last;
    // The output register refills when empty or being drained this cycle,
    // which sustains one row per cycle under continuous ready.
    assign w_load    = (r_state == STREAM) && r_have_next && (!o_out_valid || w_xfer);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_start)  w_state_next = STREAM;
            STREAM:  if (w_finish) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    genvar c;
    generate
        for (c = 0; c < N_COLS; c++) begin : g_lane
            requant_lane #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_lane (
                .i_acc     (r_snap[r_row_ptr][c]),
                .i_bias    (r_bias[c*ACC_W +: ACC_W]),
                .i_scale   (r_scale),
                .i_shift   (r_shift),
                .i_relu_en (r_relu),
                .o_q       (w_row_q[c*OUT_W +: OUT_W]),
                .o_clipped (w_clip[c])
            );
        end
    endgenerate

    // Snapshot contents are don't-care out of reset, so no reset here.
    always_ff @(posedge i_clk) begin
        if (w_capture) begin
            for (int r = 0; r < N_ROWS; r++) begin
                for (int k = 0; k < N_COLS; k++) begin
                    r_snap[r][k] <= i_acc_in_flat[(NEL-1-(r*N_COLS+k))*ACC_W +: ACC_W];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_out_valid <= 1'b0;
            o_out_data  <= '0;
            o_out_row   <= '0;
            o_out_last  <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            r_row_ptr   <= '0;
            r_have_next <= 1'b0;
            r_bias      <= '0;
            r_scale     <= '0;
            r_shift     <= '0;
            r_relu      <= 1'b0;
        end else begin
            o_done <= w_finish;
            if (w_capture) begin
                r_bias      <= i_bias_flat;
                r_scale     <= i_scale;
                r_shift     <= i_shift;
                r_relu      <= i_relu_en;
                r_row_ptr   <= '0;
                r_have_next <= 1'b1;
                o_busy      <= 1'b1;
            end
            if (w_load) begin
                o_out_valid <= 1'b1;
                o_out_data  <= w_row_q;
                o_out_row   <= r_row_ptr;
                o_out_last  <= (r_row_ptr == LAST_ROW);
                if (r_row_ptr == LAST_ROW) r_have_next <= 1'b0;
                else                       r_row_ptr   <= r_row_ptr + 1'b1;
            end else if (w_xfer) begin
                o_out_valid <= 1'b0;
            end
            if (w_finish) o_busy <= 1'b0;
        end
    end

`ifdef DRAIN_SAT_COUNT_EN
    logic [CNT_W-1:0] w_clip_cnt;
    logic [CNT_W-1:0] r_beat_clips;
    logic [16:0]      w_sat_sum;

    always_comb begin
        w_clip_cnt = '0;
        for (int k = 0; k < N_COLS; k++) w_clip_cnt = w_clip_cnt + CNT_W'(w_clip[k]);
    end

    assign w_sat_sum = {1'b0, o_sat_count} + 17'(r_beat_clips);

    // Clip count travels with the registered beat so it is credited only
    // when that beat is actually accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_sat_count  <= '0;
            r_beat_clips <= '0;
        end else begin
            if (w_load) r_beat_clips <= w_clip_cnt;
            if (w_capture)   o_sat_count <= '0;
            else if (w_xfer) o_sat_count <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
        end
    end
`else
    logic w_unused_clip;
    assign w_unused_clip = ^w_clip;
`endif

endmodule

// File: doc/systolic_drain_requant.md
Name: systolic_drain_requant

Overview:
- Downstream stage of the weight-stationary systolic array.
- On a start pulse, snapshots the array's full INT32 accumulator bus (N_ROWS x N_COLS).
- Requantizes each element to INT8: bias add, scale multiply, rounding right-shift, optional ReLU, saturation.
- Streams results one array row per beat over a valid/ready interface toward the output buffer / writeback DMA.

Parameters:
- N_ROWS, 14, array rows; number of output beats per drain.
- N_COLS, 14, array columns; INT8 lanes per beat.
- ACC_W, 32, accumulator width per PE.
- OUT_W, 8, output lane width (signed).

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; capture acc_in_flat and begin drain
- acc_in_flat  in  N_ROWS*N_COLS*ACC_W  array accumulators. Element (r,c) sits at bit offset (N_ROWS*N_COLS-1-(r*N_COLS+c))*ACC_W, so (0,0) is in the MSBs.
- bias_flat  in  N_COLS*ACC_W  per-column signed bias; lane c at [c*ACC_W +: ACC_W]
- scale  in  16  unsigned multiplier
- shift  in  5  arithmetic right-shift amount, 0..31
- relu_en  in  1  clamp negatives to 0 before saturation
- out_valid  out  1  beat valid
- out_ready  in  1  consumer ready
- out_data  out  N_COLS*OUT_W  lane c at [c*OUT_W +: OUT_W]
- out_row  out  $clog2(N_ROWS)  row index of current beat
- out_last  out  1  high on the beat for row N_ROWS-1
- busy  out  1  high from the capture cycle until the last beat is accepted
- done  out  1  one-cycle pulse after the last beat handshake

Behaviour:
- Reset: state IDLE. out_valid, out_data, out_row, out_last, busy and done are all 0. Snapshot contents are don't-care.
- FSM states: IDLE, STREAM.
  - IDLE + start: register acc_in_flat into snapshot; latch bias, scale, shift and relu_en; row_ptr=0; busy=1; go to STREAM.
  - STREAM: out_data is a registered requant of snapshot row row_ptr. First out_valid is asserted 2 cycles after the start cycle (T+2). The cycle after capture computes and registers row 0.
- Handshake:
  - Transfer occurs when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data, out_row and out_last are held stable.
  - On transfer of a non-last row, the next row is presented the following cycle. Back-to-back beats are sustained, so throughput is 1 row/cycle under continuous ready.
  - out_valid never drops without a transfer.
- Last row: the transfer with out_last=1 causes:
  - next cycle: out_valid=0, busy=0, done=1 for exactly 1 cycle, return to IDLE.
- start while busy is ignored; the snapshot is not modified. start in the same cycle as the done pulse is accepted (state is IDLE).
- Config changes mid-drain have no effect, because config is latched at start.
- rst mid-drain: next cycle all outputs return to reset values, state IDLE, and no done pulse is issued.
- Arithmetic per lane, all signed unless noted:
  - s = acc + bias, 33-bit.
  - p = s * {1'b0,scale}, 50-bit.
  - rnd = (shift==0) ? 0 : (1 << (shift-1)).
  - q = (p + rnd) >>> shift. This is round-half-up toward +inf.
  - If relu_en and q<0, then q=0.
  - Saturate to [-128,127].
  - No intermediate overflow is permitted; widths are sized to be exact.
- N_ROWS=1: a single beat, with out_last=1 on row 0.

Optional Feature:
- Macro DRAIN_SAT_COUNT_EN.
- When defined, adds output sat_count [15:0]:
  - Cleared at start capture.
  - Increments by the number of lanes clipped (q>127 or q<-128, after ReLU) on each accepted beat.
  - Saturates at 16'hFFFF and holds its value after done.
  - Reset value is 0.
- When undefined, the port and counter are absent, and there is no other behavioural change.

Decomposition:
- Package systolic_drain_pkg holds:
  - ACC_W and OUT_W default constants.
  - The state enum (IDLE, STREAM).
  - The rounding/saturation width constants (SUM_W=33, PROD_W=50).
  - The INT8 min/max constants.
- Sub-module requant_lane: purely combinational single-element datapath (acc, bias, scale, shift, relu_en to q_sat and clipped flag). It is instantiated N_COLS times; the top holds the FSM, snapshot and output register.

Test Plan (bench N_ROWS=N_COLS=2):
- Rounding: acc={1000,-1000,4,-4}, bias=0, scale=1, shift=3, relu_en=0, ready=1 -> row0={125,-125}, row1={1,0}. First valid at T+2, out_last on row1, done 1 cycle later.
- Saturation/ReLU: acc={2000,-2000,7,-7}, scale=1, shift=3 -> {127,-128,1,-1}; with relu_en=1 -> {127,0,1,0}. With DRAIN_SAT_COUNT_EN, sat_count=2 (relu_en=0) and 1 (relu_en=1).
- Bias and scale: acc=100, bias=-50, scale=3, shift=1 -> (150+1)>>>1=75 in every lane. shift=0, scale=0 -> all 0.
- Backpressure: out_ready low for 3 cycles while row0 is valid -> out_data/out_row stable. Rows are then delivered 0,1 in order and no beat is dropped or duplicated.
- start during busy: a second start with different acc_in_flat at row0 -> ignored, and the output matches the first snapshot. A start in the done cycle launches a new drain.
- Reset mid-drain: rst asserted after row0 is accepted -> next cycle out_valid=0, busy=0, and no done pulse. A subsequent start drains normally from row 0.
